adaptive_filter_sched: RTL

Round-robin scheduler that shares the single 32-tap adaptive-filter MAC engine among four delay channels. It grants one requesting channel at a time and selects that channel's buffers and weights through `sel`. It then sequences the engine's `adap_filter_state` and `div_state` phases for a fixed cycle budget and reports completion with a one-cycle `done` pulse tagged with the channel number. It sits between the per-channel buffer/weight stores and the filter datapath.

---
 rtl/adaptive_filter_pkg.sv | 22 ++
 rtl/adaptive_filter_sched_rr_arbiter.sv | 29 ++
 rtl/adaptive_filter_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/adaptive_filter_pkg.sv
// Shared types and constants for the adaptive-filter MAC scheduler.
// Engine phase budgets live here so channel stores and scheduler agree.
package adaptive_filter_pkg;

    localparam int NCH   = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 6;

    localparam int RUN_CYC_DEF   = 35;
    localparam int DRAIN_CYC_DEF = 2;
    localparam int DIV_CYC_DEF   = 18;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/adaptive_filter_sched_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after
// the pointer, searching upward modulo the channel count.
module rr_arbiter
    import adaptive_filter_pkg::*;
#(
    parameter int N = NCH,
    parameter int W = CH_W
) (
    input  logic [N-1:0] elig_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] pick_oh_o,
    output logic [W-1:0] pick_idx_o,
    output logic         pick_vld_o
);

    always_comb begin
        pick_oh_o  = '0;
        pick_idx_o = '0;
        pick_vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!pick_vld_o && elig_i[(int'(ptr_i) + i) % N]) begin
                pick_vld_o = 1'b1;
                pick_idx_o = W'((int'(ptr_i) + i) % N);
                pick_oh_o[(int'(ptr_i) + i) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adaptive_filter_sched.sv
// Shares one 32-tap adaptive-filter MAC engine among the delay channels,
// sequencing its run/drain/divide phases for the granted channel.
module adaptive_filter_sched #(
    parameter int NCH       = adaptive_filter_pkg::NCH,
    parameter int RUN_CYC   = adaptive_filter_pkg::RUN_CYC_DEF,
    parameter int DRAIN_CYC = adaptive_filter_pkg::DRAIN_CYC_DEF,
    parameter int DIV_CYC   = adaptive_filter_pkg::DIV_CYC_DEF
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NCH-1:0]                    req,
    input  logic [NCH-1:0]                    en_mask,
    output logic [NCH-1:0]                    grant,
    output logic [adaptive_filter_pkg::CH_W-1:0] sel,
    output logic                              load,
    output logic                              adap_filter_state,
    output logic                              div_state,
    output logic                              done,
    output logic [adaptive_filter_pkg::CH_W-1:0] done_ch,
    output logic                              busy,
    output logic [15:0]                       op_count
);

    import adaptive_filter_pkg::*;

    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  rr_ptr_q;
    logic [NCH-1:0]   grant_q;
    logic [CH_W-1:0]  sel_q;
    logic [CH_W-1:0]  done_ch_q;
    logic             load_q, afs_q, div_q, done_q, busy_q;
    logic [15:0]      op_cnt_q;

    logic [NCH-1:0]   elig;
    logic [NCH-1:0]   pick_oh;
    logic [CH_W-1:0]  pick_idx;
    logic             pick_vld;

    assign elig = req & en_mask;

    rr_arbiter #(
        .N (NCH),
        .W (CH_W)
    ) u_arb (
        .elig_i     (elig),
        .ptr_i      (rr_ptr_q),
        .pick_oh_o  (pick_oh),
        .pick_idx_o (pick_idx),
        .pick_vld_o (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (pick_vld) state_d = LOAD;
            LOAD:  state_d = RUN;
            RUN:   if (cnt_q == RUN_LAST) state_d = DRAIN;
            DRAIN: if (cnt_q == DRAIN_LAST)
                       state_d = (DIV_CYC == 0) ? DONE : DIV;
            DIV:   if (cnt_q == DIV_LAST) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase counter restarts on every state entry.
    assign cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            done_ch_q <= '0;
            load_q    <= 1'b0;
            afs_q     <= 1'b0;
            div_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            op_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= (state_d == LOAD);
            afs_q   <= (state_d == RUN);
            div_q   <= (state_d == DIV);
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
            if (state_q == IDLE && state_d == LOAD) begin
                grant_q <= pick_oh;
                sel_q   <= pick_idx;
            end else if (state_d == IDLE) begin
                grant_q <= '0;
            end
            if (state_d == DONE) begin
                done_ch_q <= sel_q;
                op_cnt_q  <= op_cnt_q + 16'd1;
            end
            if (state_q == DONE)
                rr_ptr_q <= CH_W'((int'(sel_q) + 1) % NCH);
        end
    end

    assign grant             = grant_q;
    assign sel               = sel_q;
    assign load              = load_q;
    assign adap_filter_state = afs_q;
    assign div_state         = div_q;
    assign done              = done_q;
    assign done_ch           = done_ch_q;
    assign busy              = busy_q;
    assign op_count          = op_cnt_q;

endmodule
